piece_ctl: RTL and testbench
============================

// Module: piece_ctl
// PURPOSE
//  Falling-piece controller for the playfield renderer. Owns position, shape and rotation of the
//  active piece and drives xpos/ypos/block/rot of the downstream rectangle-draw stage.
//  Grid units are cells (col, row), not pixels. Applies gravity once per DROP_FRAMES frames and
//  button moves. Signals lock at the floor, then spawns a new pseudo-random piece.
// PARAMETERS
//  COLS        10       playfield width in cells
//  ROWS        20       playfield height in cells
//  COL_SPAWN   3        spawn column of a new piece
//  DROP_FRAMES 30       frames per one-row gravity step (>=2)
//  LFSR_SEED   16'hACE1 LFSR reset value (nonzero)
// PORTS
//  pclk       in   1   pixel clock, all logic on rising edge
//  rst        in   1   asynchronous, active-low reset
//  vsync_in   in   1   vertical sync from timing chain; rising edge = frame tick
//  start      in   1   level; rising edge leaves IDLE
//  btn_left   in   1   debounced level; rising edge = move left one column
//  btn_right  in   1   debounced level; rising edge = move right one column
//  btn_rot    in   1   debounced level; rising edge = rotate
//  btn_down   in   1   debounced level; soft drop (see CONFIGURATION)
//  xpos       out  12  piece column, zero-extended
//  ypos       out  12  piece row, zero-extended
//  block      out  3   shape code: 0=I,1=O,2=T,3=S,4=Z,5=J,6=L
//  rot        out  3   rotation 0..3; bit 2 always 0
//  locked     out  1   1-cycle pulse when the piece lands
//  active     out  1   high in FALL state
// BEHAVIOUR
//  - Reset (rst=0): xpos=COL_SPAWN, ypos=0, block=0, rot=0, locked=0, active=0.
//    Internal state: state=IDLE, frame_cnt=0, lfsr=LFSR_SEED, all edge-detect regs=0.
//  - Edge detect: each input gets one register; edge = in & ~in_d. The action occurs on the
//    clock after the edge is sampled. Inputs are already synchronous to pclk.
//  - Footprint: W=4,H=1 for block 0 (I); W=2,H=2 for all others. Rotation does not alter footprint.
//  - LFSR: 16-bit Galois, taps 16,14,13,11. Advances every pclk in every state except reset.
//  - FSM IDLE -> SPAWN -> FALL -> LOCK -> SPAWN:
//    IDLE : outputs hold; start edge -> SPAWN.
//    SPAWN: 1 cycle; block = lfsr[2:0], with 7 mapped to 0; xpos=COL_SPAWN, ypos=0, rot=0,
//           frame_cnt=0 -> FALL.
//    FALL : active=1; moves and gravity below; floor reached on a gravity step -> LOCK.
//    LOCK : 1 cycle; locked=1; position/block held -> SPAWN.
//  - Moves, FALL only:
//    left  : if xpos>0, xpos-1.
//    right : if xpos+W<COLS, xpos+1.
//    Left and right edges in the same cycle -> no move.
//    rot   : rot=(rot+1) mod 4.
//    Edges arriving in other states are dropped, not queued.
//  - Gravity, FALL only: on frame tick, if frame_cnt==DROP_FRAMES-1 then frame_cnt=0 and do a
//    step; else frame_cnt+1.
//    Step: if ypos+H<ROWS, ypos+1; else -> LOCK and ypos unchanged.
//  - A horizontal move and a gravity step in the same cycle both apply.
//  - start edge outside IDLE is ignored. There is no game-over; playfield contents are not tracked.
//  - Reset asserted mid-fall returns to IDLE with reset values on the next rst assertion
//    (asynchronous).
// CONFIGURATION
//  PIECE_CTL_SOFT_DROP_EN
//    defined  : while btn_down=1 in FALL, every frame tick is a gravity step and frame_cnt is
//               forced to 0. On btn_down release, the normal count restarts from 0.
//    undefined: btn_down is ignored; only DROP_FRAMES gravity applies.
// TESTING
//  1 reset, start pulse -> SPAWN 1 cycle later; block in 0..6, xpos=3, ypos=0, rot=0, active=1.
//  2 DROP_FRAMES=2, 4 vsync pulses -> ypos steps 0->1->2; each step on the 2nd tick.
//  3 block 1 at xpos=0: left edge -> xpos stays 0.
//    Same block, 9 right edges -> xpos saturates at 8.
//    Block 0: xpos saturates at 6.
//  4 left+right edges in the same cycle -> xpos unchanged.
//    btn_rot held high 100 cycles -> rot advances by exactly 1.
//  5 block 1 falls to ypos=18, next step -> locked high exactly 1 cycle.
//    Then SPAWN with ypos=0, xpos=3; LFSR-derived block never equals 7.
//  6 With PIECE_CTL_SOFT_DROP_EN defined, btn_down=1 -> ypos+1 per vsync.
//    Without the macro -> DROP_FRAMES rate unchanged.
//    rst pulled low mid-fall -> all outputs at reset values, active=0.

Source files
------------

// File: rtl/piece_ctl.sv
// piece_ctl: falling-piece controller. It tracks the position, shape and rotation of the active piece in cell units.
// Latency: a button or vsync edge is acted on at the clock where it is first sampled, and the new position is visible on the next cycle.
// No backpressure: edges that arrive outside FALL are dropped. Soft drop is enabled by defining PIECE_CTL_SOFT_DROP_EN.
module piece_ctl #(
    parameter int          COLS        = 10,
    parameter int          ROWS        = 20,
    parameter int          COL_SPAWN   = 3,
    parameter int          DROP_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rot,
    input  logic        btn_down,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [2:0]  block,
    output logic [2:0]  rot,
    output logic        locked,
    output logic        active
);
    localparam int FCW = $clog2(DROP_FRAMES);

    typedef enum logic [1:0] {IDLE, SPAWN, FALL, LOCK} state_t;

    state_t         state_q, state_d;
    logic [11:0]    xpos_q, xpos_d;
    logic [11:0]    ypos_q, ypos_d;
    logic [2:0]     block_q, block_d;
    logic [1:0]     rot_q, rot_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic           vsync_q, start_q, left_q, right_q, rotb_q;

    logic           vsync_edge, start_edge, left_edge, right_edge, rot_edge;
    logic           soft_drop, step;
    logic [11:0]    pw, ph;

    assign vsync_edge = vsync_in  & ~vsync_q;
    assign start_edge = start     & ~start_q;
    assign left_edge  = btn_left  & ~left_q;
    assign right_edge = btn_right & ~right_q;
    assign rot_edge   = btn_rot   & ~rotb_q;

`ifdef PIECE_CTL_SOFT_DROP_EN
    assign soft_drop = btn_down;
`else
    logic unused_btn_down;
    assign unused_btn_down = btn_down;
    assign soft_drop       = 1'b0;
`endif

    // I piece is a 4x1 bar; every other shape occupies a 2x2 box regardless of rotation
    assign pw = (block_q == 3'd0) ? 12'd4 : 12'd2;
    assign ph = (block_q == 3'd0) ? 12'd1 : 12'd2;

    // Galois form, taps 16,14,13,11
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        state_d     = state_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        block_d     = block_q;
        rot_d       = rot_q;
        frame_cnt_d = frame_cnt_q;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = SPAWN;
            end
            SPAWN: begin
                block_d     = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
                xpos_d      = 12'(COL_SPAWN);
                ypos_d      = 12'd0;
                rot_d       = 2'd0;
                frame_cnt_d = '0;
                state_d     = FALL;
            end
            FALL: begin
                if (left_edge && !right_edge && xpos_q != 12'd0)
                    xpos_d = xpos_q - 12'd1;
                else if (right_edge && !left_edge && (xpos_q + pw) < 12'(COLS))
                    xpos_d = xpos_q + 12'd1;
                if (rot_edge) rot_d = rot_q + 2'd1;
                if (soft_drop) begin
                    frame_cnt_d = '0;
                    step        = vsync_edge;
                end else if (vsync_edge) begin
                    if (frame_cnt_q == FCW'(DROP_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        step        = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
                if (step) begin
                    if ((ypos_q + ph) < 12'(ROWS)) ypos_d = ypos_q + 12'd1;
                    else                           state_d = LOCK;
                end
            end
            LOCK:    state_d = SPAWN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            xpos_q      <= 12'(COL_SPAWN);
            ypos_q      <= 12'd0;
            block_q     <= 3'd0;
            rot_q       <= 2'd0;
            frame_cnt_q <= '0;
            lfsr_q      <= LFSR_SEED;
            vsync_q     <= 1'b0;
            start_q     <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            rotb_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            block_q     <= block_d;
            rot_q       <= rot_d;
            frame_cnt_q <= frame_cnt_d;
            lfsr_q      <= lfsr_d;
            vsync_q     <= vsync_in;
            start_q     <= start;
            left_q      <= btn_left;
            right_q     <= btn_right;
            rotb_q      <= btn_rot;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign block  = block_q;
    assign rot    = {1'b0, rot_q};
    assign locked = (state_q == LOCK);
    assign active = (state_q == FALL);
endmodule

// File: tb/tb_piece_ctl.sv
// Directed bench for piece_ctl with DROP_FRAMES=2. Each scenario lives in its own task and checks its results inline.
module tb_piece_ctl;
    logic        pclk = 1'b0;
    logic        rst = 1'b0, vsync_in = 1'b0, start = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_down = 1'b0;
    logic [11:0] xpos, ypos;
    logic [2:0]  block, rot;
    logic        locked, active;

    int errors = 0, checks = 0;
    int lock_cnt = 0, block7_cnt = 0;
    int exp_y, exp_cnt;
    bit found;

    piece_ctl #(.DROP_FRAMES(2)) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
        .xpos(xpos), .ypos(ypos), .block(block), .rot(rot), .locked(locked), .active(active)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (locked) lock_cnt++;
        if (block == 3'd7) block7_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; vsync_in = 1'b0; start = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_down = 1'b0;
        #12;
        rst = 1'b1;
        tick(1);
    endtask

    task automatic start_game;
        start = 1'b1; tick(1);
        start = 1'b0; tick(2);
    endtask

    task automatic vsync_pulse;
        vsync_in = 1'b1; tick(1);
        vsync_in = 1'b0; tick(1);
    endtask

    // 0=left 1=right 2=rot 3=left+right together
    task automatic press(input int which);
        btn_left  = (which == 0 || which == 3);
        btn_right = (which == 1 || which == 3);
        btn_rot   = (which == 2);
        tick(1);
        btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0;
        tick(1);
    endtask

    // Vary the start time after reset until the pseudo-random spawn gives the wanted shape
    task automatic find_block(input int target);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            rst = 1'b0; #3; rst = 1'b1;
            tick(t + 1);
            start_game;
            if (block == 3'(target) && active) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL find_block: block %0d never spawned, last=%0d", target, block); end
    endtask

    task automatic test_reset;
        rst = 1'b0; #12;
        checks++;
        if ({xpos, ypos, block, rot, locked, active} !== {12'd3, 12'd0, 3'd0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: x=%0d y=%0d blk=%0d rot=%0d lk=%b act=%b, need 3 0 0 0 0 0", xpos, ypos, block, rot, locked, active);
        end
        rst = 1'b1; tick(1);
    endtask

    task automatic test_idle_drop;
        do_reset;
        press(1);
        checks++;
        if (xpos !== 12'd3 || active !== 1'b0) begin errors++; $display("FAIL idle_drop: x=%0d act=%b, need 3 0", xpos, active); end
    endtask

    task automatic test_spawn;
        do_reset;
        start = 1'b1; tick(1); start = 1'b0;
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL spawn_cycle: active=%b need 0", active); end
        tick(1);
        checks++;
        if (active !== 1'b1 || xpos !== 12'd3 || ypos !== 12'd0 || rot !== 3'd0 || block > 3'd6) begin
            errors++;
            $display("FAIL spawn: act=%b x=%0d y=%0d rot=%0d blk=%0d, need 1 3 0 0 <=6", active, xpos, ypos, rot, block);
        end
    endtask

    task automatic test_gravity;
        int exp_seq [4] = '{0, 1, 1, 2};
        for (int i = 0; i < 4; i++) begin
            vsync_pulse;
            checks++;
            if (ypos !== 12'(exp_seq[i])) begin errors++; $display("FAIL gravity tick %0d: y=%0d need %0d", i + 1, ypos, exp_seq[i]); end
        end
    endtask

    task automatic test_moves;
        find_block(1);
        repeat (3) press(0);
        checks++;
        if (xpos !== 12'd0) begin errors++; $display("FAIL left_to_0: x=%0d need 0", xpos); end
        press(0);
        checks++;
        if (xpos !== 12'd0) begin errors++; $display("FAIL left_wall: x=%0d need 0", xpos); end
        repeat (9) press(1);
        checks++;
        if (xpos !== 12'd8) begin errors++; $display("FAIL right_wall_O: x=%0d need 8", xpos); end
        press(0);
        press(3);
        checks++;
        if (xpos !== 12'd7) begin errors++; $display("FAIL left_right_same: x=%0d need 7", xpos); end
        btn_rot = 1'b1; tick(100); btn_rot = 1'b0; tick(1);
        checks++;
        if (rot !== 3'd1) begin errors++; $display("FAIL rot_held: rot=%0d need 1", rot); end
        repeat (3) press(2);
        checks++;
        if (rot !== 3'd0) begin errors++; $display("FAIL rot_wrap: rot=%0d need 0", rot); end
        find_block(0);
        repeat (9) press(1);
        checks++;
        if (xpos !== 12'd6) begin errors++; $display("FAIL right_wall_I: x=%0d need 6", xpos); end
    endtask

    task automatic test_lock;
        int l0;
        find_block(1);
        repeat (36) vsync_pulse;
        checks++;
        if (ypos !== 12'd18) begin errors++; $display("FAIL fall_to_floor: y=%0d need 18", ypos); end
        vsync_pulse;
        checks++;
        if (ypos !== 12'd18 || locked !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL pre_lock: y=%0d lk=%b act=%b, need 18 0 1", ypos, locked, active);
        end
        l0 = lock_cnt;
        vsync_in = 1'b1; tick(1);
        checks++;
        if (locked !== 1'b1 || ypos !== 12'd18) begin errors++; $display("FAIL lock_pulse: lk=%b y=%0d need 1 18", locked, ypos); end
        vsync_in = 1'b0; tick(3);
        checks++;
        if (lock_cnt - l0 !== 1) begin errors++; $display("FAIL lock_width: %0d cycles need 1", lock_cnt - l0); end
        checks++;
        if (ypos !== 12'd0 || xpos !== 12'd3 || active !== 1'b1) begin
            errors++; $display("FAIL respawn: y=%0d x=%0d act=%b, need 0 3 1", ypos, xpos, active);
        end
    endtask

    // Reference gravity model: soft drop steps on every tick, otherwise one step per two ticks
    task automatic test_soft_drop;
        bit sd;
        do_reset;
        start_game;
        exp_y = 0; exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            btn_down = (i < 3);
`ifdef PIECE_CTL_SOFT_DROP_EN
            sd = btn_down;
`else
            sd = 1'b0;
`endif
            if (sd) begin exp_y++; exp_cnt = 0; end
            else if (exp_cnt == 1) begin exp_y++; exp_cnt = 0; end
            else exp_cnt++;
            vsync_pulse;
            checks++;
            if (ypos !== 12'(exp_y)) begin errors++; $display("FAIL soft_drop tick %0d: y=%0d need %0d", i + 1, ypos, exp_y); end
        end
        btn_down = 1'b0;
    endtask

    task automatic test_async_reset;
        logic [11:0] y0;
        y0 = ypos;
        start = 1'b1; tick(1); start = 1'b0; tick(2);
        checks++;
        if (ypos !== y0 || active !== 1'b1) begin errors++; $display("FAIL start_in_fall: y=%0d act=%b need %0d 1", ypos, active, y0); end
        press(2);
        press(1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({xpos, ypos, block, rot, locked, active} !== {12'd3, 12'd0, 3'd0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: x=%0d y=%0d blk=%0d rot=%0d lk=%b act=%b, need 3 0 0 0 0 0", xpos, ypos, block, rot, locked, active);
        end
        #10 rst = 1'b1;
        tick(3);
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL idle_after_reset: act=%b need 0", active); end
    endtask

    initial begin
        test_reset;
        test_idle_drop;
        test_spawn;
        test_gravity;
        test_moves;
        test_lock;
        test_soft_drop;
        test_async_reset;
        checks++;
        if (block7_cnt !== 0) begin errors++; $display("FAIL block7: seen %0d cycles need 0", block7_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
